// File: rtl/vs_xform_sched.sv
// vs_xform_sched: round-robin vertex scheduler driving an external 4x4 matrix-vector datapath.
// Optional macro VS_XFORM_SAT_EN: saturate each result lane to the signed lane range instead of wrapping.
module vs_xform_sched #(
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_REQ     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mat_we,
  input  logic [1:0]                  mat_row,
  input  logic [4*FIXED_WIDTH-1:0]    mat_data,
  output logic                        mat_ready,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*4*FIXED_WIDTH-1:0] req_vec,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [4*FIXED_WIDTH-1:0]    dp_a0,
  output logic [4*FIXED_WIDTH-1:0]    dp_a1,
  output logic [4*FIXED_WIDTH-1:0]    dp_a2,
  output logic [4*FIXED_WIDTH-1:0]    dp_a3,
  output logic [FIXED_WIDTH-1:0]      dp_x0,
  output logic [FIXED_WIDTH-1:0]      dp_x1,
  output logic [FIXED_WIDTH-1:0]      dp_x2,
  output logic [FIXED_WIDTH-1:0]      dp_x3,
  input  logic signed [31:0]          dp_y0,
  input  logic signed [31:0]          dp_y1,
  input  logic signed [31:0]          dp_y2,
  input  logic signed [31:0]          dp_y3,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_id,
  output logic [4*FIXED_WIDTH-1:0]    out_vec,
  output logic [15:0]                 done_cnt
);
  localparam int VW       = 4 * FIXED_WIDTH;
  localparam int LANE_MAX = (1 << (FIXED_WIDTH - 1)) - 1;
  localparam int LANE_MIN = -(1 << (FIXED_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    mat_q [4];
  logic [VW-1:0]    x_q, x_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       last_q, last_d;
  logic [VW-1:0]    out_vec_q, out_vec_d;
  logic [15:0]      done_q, done_d;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic signed [31:0] y_w [4];
  logic [VW-1:0]    lanes_w;

  function automatic logic [VW-1:0] ident_row(input int r);
    logic [VW-1:0] v;
    v = '0;
    v[VW-1-FIXED_WIDTH*r -: FIXED_WIDTH] = FIXED_WIDTH'(1 << FRAC_BITS);
    return v;
  endfunction

  assign y_w[0] = dp_y0;
  assign y_w[1] = dp_y1;
  assign y_w[2] = dp_y2;
  assign y_w[3] = dp_y3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [31:0] sh_w;
      assign sh_w = y_w[gi] >>> FRAC_BITS;
`ifdef VS_XFORM_SAT_EN
      assign lanes_w[VW-1-FIXED_WIDTH*gi -: FIXED_WIDTH] =
        (sh_w > LANE_MAX) ? FIXED_WIDTH'(LANE_MAX) :
        (sh_w < LANE_MIN) ? FIXED_WIDTH'(LANE_MIN) : sh_w[FIXED_WIDTH-1:0];
`else
      logic unused_w;
      assign unused_w = ^sh_w[31:FIXED_WIDTH];
      assign lanes_w[VW-1-FIXED_WIDTH*gi -: FIXED_WIDTH] = sh_w[FIXED_WIDTH-1:0];
`endif
    end
  endgenerate

  // Lowest offset from last_q wins, so the search starts at last_q+1 and last_q itself is tried last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[last_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = last_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    id_d      = id_q;
    last_d    = last_q;
    out_vec_d = out_vec_q;
    done_d    = done_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        // A matrix write blocks the grant so the next vertex sees the updated row.
        if (rst_n && !mat_we && grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          x_d     = req_vec[int'(grant_idx)*VW +: VW];
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        out_vec_d = lanes_w;
        state_d   = OUT;
      end
      OUT: begin
        if (out_ready) begin
          done_d  = done_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      id_q      <= '0;
      last_q    <= 2'd3;
      out_vec_q <= '0;
      done_q    <= '0;
      for (int r = 0; r < 4; r++) mat_q[r] <= ident_row(r);
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      id_q      <= id_d;
      last_q    <= last_d;
      out_vec_q <= out_vec_d;
      done_q    <= done_d;
      if (state_q == IDLE && mat_we) mat_q[mat_row] <= mat_data;
    end
  end

  assign mat_ready = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_id    = id_q;
  assign out_vec   = out_vec_q;
  assign done_cnt  = done_q;
  assign dp_a0     = mat_q[0];
  assign dp_a1     = mat_q[1];
  assign dp_a2     = mat_q[2];
  assign dp_a3     = mat_q[3];
  assign dp_x0     = x_q[VW-1 -: FIXED_WIDTH];
  assign dp_x1     = x_q[VW-1-FIXED_WIDTH -: FIXED_WIDTH];
  assign dp_x2     = x_q[VW-1-2*FIXED_WIDTH -: FIXED_WIDTH];
  assign dp_x3     = x_q[FIXED_WIDTH-1:0];
endmodule

// File: doc/vs_xform_sched.md
VS_XFORM_SCHED -- requirements
Module: vs_xform_sched

Interface
REQ-001 Parameters (name, default, meaning): FIXED_WIDTH, 16, element width of matrix/vector entries.
REQ-002 FRAC_BITS, 8, fractional bits of the fixed-point format.
REQ-003 NUM_REQ, 4, number of vertex requesters (fixed at 4 in this revision).
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- mat_we  in  1  matrix row write strobe.
- mat_row  in  2  row index for the write.
- mat_data  in  64  row data, {a0,a1,a2,a3} with a0 in the MSBs.
- mat_ready  out  1  high only in IDLE.
- req_valid  in  4  per-requester vertex valid.
- req_vec  in  256  per-requester vertex; requester i occupies [64i+63:64i] as {x0,x1,x2,x3}.
- req_ready  out  4  one-hot grant, or all zero.
- dp_a0..dp_a3  out  64 each  matrix rows to the matrix-vector datapath.
- dp_x0..dp_x3  out  16 each  vector to the datapath.
- dp_y0..dp_y3  in  32 signed each  datapath results.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_id  out  2  index of the requester that produced the result.
- out_vec  out  64  {y0,y1,y2,y3}, 16 bits each.
- done_cnt  out  16  count of completed results.

Function
REQ-006 FSM states: IDLE, CALC, OUT; exactly one vertex in flight.
REQ-007 In IDLE with mat_we=0 and any req_valid set, assert req_ready for exactly one requester, chosen round-robin: search starts at last_grant+1 mod 4.
- A transfer occurs when req_valid[i] & req_ready[i].
REQ-008 On a transfer (cycle t):
- latch the vector into the X register;
- latch i into the id register;
- update last_grant to i;
- go to CALC.
REQ-009 In CALC (t+1): dp_x* and dp_a* come from registers only. At the end of the cycle, register each dp_yk into out_vec lane k and go to OUT. out_valid is first high in cycle t+2.
REQ-010 Result arithmetic: lane = dp_yk >>> FRAC_BITS (arithmetic shift), then reduced to 16 bits per REQ-019.
REQ-011 In OUT: out_valid=1; out_vec and out_id are held stable until out_valid & out_ready.
- On that handshake: increment done_cnt (wraps 0xFFFF -> 0) and go to IDLE.
- The next transfer is possible one cycle after the handshake.
REQ-012 req_ready is all zero in CALC and OUT, and in any IDLE cycle with mat_we=1.
REQ-013 Matrix write in IDLE with mat_we=1: row mat_row <= mat_data.
- A simultaneous request is not granted that cycle, so the vertex uses the new matrix.
REQ-014 mat_we outside IDLE is ignored and the matrix is unchanged.
REQ-015 dp_a0..dp_a3 always equal matrix rows 0..3. dp_x* equal the X register.

Reset
REQ-016 When rst_n=0 at a clock edge, in any state including mid-operation:
- state=IDLE; out_valid=0; out_vec=0; out_id=0; done_cnt=0;
- X register=0; last_grant=3, so requester 0 has first priority;
- matrix=identity: diagonal 0x0100 (1<<FRAC_BITS), off-diagonal 0.
REQ-017 req_ready=0 and mat_ready=0 while rst_n=0.
REQ-018 Any in-flight vertex is discarded on reset and never appears on out_*.

Configuration
REQ-019 Macro VS_XFORM_SAT_EN:
- Defined: each shifted lane saturates to the 16-bit signed range [0x8000, 0x7FFF].
- Undefined: each shifted lane is truncated to its low 16 bits (wraps).

Verification
REQ-020 After reset, requester 0 sends {0x0100,0x0200,0xFF00,0x0000} -> out_valid at t+2, out_vec=0x0100_0200_FF00_0000, out_id=0.
REQ-021 Write the diagonal to 0x7FFF; send x0=0x7FFF (other lanes 0) -> lane 0 = 0x7FFF with VS_XFORM_SAT_EN, 0xFF00 without.
REQ-022 req_valid=4'b1111 held, out_ready=1 -> out_id sequence 0,1,2,3,0; done_cnt=5 after the 5th handshake.
REQ-023 out_ready=0 for 10 cycles in OUT -> out_valid and out_vec stable, req_ready=0; single handshake when out_ready=1, done_cnt +1.
REQ-024 In IDLE: mat_we=1 (row 0 = 0x0200_0000_0000_0000) with req_valid[2]=1 -> no grant that cycle; next cycle grant 2; lane 0 result = 2*x0.
REQ-025 rst_n=0 during CALC -> next cycle IDLE, out_valid=0, done_cnt=0, matrix back to identity; no stale result emitted.
